sparc_windowed_regfile: RTL and testbench

//  SPARC V8-style windowed integer register file: 32-bit data, 4 overlapping windows, 2 async read ports, 1 sync write/clear port.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_addr_map.sv | 28 ++
 rtl/sparc_windowed_regfile.sv | 71 +++++++
 tb/tb_sparc_windowed_regfile.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the SPARC-style windowed register file.
//
// Purpose: sizes of the logical and physical register spaces, and the type
// used for a physical register index.
//
// Configuration: none here. The top level honours REGFILE_BYPASS_EN.
package regfile_pkg;

   localparam int DATA_W   = 32;
   localparam int NWIN     = 4;
   localparam int WIN_W    = 2;
   localparam int NGLOBAL  = 8;
   localparam int WIN_REGS = 16;
   localparam int NPHYS    = NGLOBAL + NWIN * WIN_REGS;
   localparam int ADDR_W   = 5;
   localparam int PHYS_W   = 7;

   typedef logic [PHYS_W-1:0] physIdx_t;

endpackage

// File: rtl/regfile_addr_map.sv
// Logical-to-physical register index translation for one access port.
//
// Ports:
//   addr_i  in  5  logical register r0..r31
//   win_i   in  2  current window pointer
//   phys_o  out 7  physical index: 0..7 globals, 8..71 windowed storage
module regfile_addr_map
   import regfile_pkg::*;
(
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [WIN_W-1:0]  win_i,
   output physIdx_t          phys_o
);

   logic [5:0] winOffset;

   // A 6-bit sum wraps modulo 64. That gives window 0's outs the same
   // storage as window 3's ins without an explicit compare.
   always_comb begin
      winOffset = {win_i, 4'b0000} + {1'b0, addr_i} - 6'd8;
      if (addr_i < ADDR_W'(NGLOBAL)) begin
         phys_o = physIdx_t'(addr_i);
      end else begin
         phys_o = physIdx_t'(NGLOBAL) + {1'b0, winOffset};
      end
   end

endmodule

// File: rtl/sparc_windowed_regfile.sv
// SPARC V8-style windowed integer register file.
//
// It has 4 overlapping windows of 32 logical registers. These are backed by
// 72 physical registers: 8 globals plus 64 windowed registers. The file has
// two combinational read ports and one synchronous write/clear port.
//
// Ports:
//   Clk            in   1   clock, rising edge
//   Clr            in   1   synchronous clear of the register at PC_in/current_window
//   PA_out         out  32  read data, port A
//   PB_out         out  32  read data, port B
//   in             in   32  write data
//   PA_in          in   5   read address, port A
//   PB_in          in   5   read address, port B
//   PC_in          in   5   write/clear address
//   enable         in   1   write enable
//   current_window in   2   current window pointer
//
// Configuration: define REGFILE_BYPASS_EN so that a read of the register
// being written or cleared returns the pending value in the same cycle.
module sparc_windowed_regfile
   import regfile_pkg::*;
(
   input  logic                     Clk,
   input  logic                     Clr,
   output logic signed [DATA_W-1:0] PA_out,
   output logic signed [DATA_W-1:0] PB_out,
   input  logic signed [DATA_W-1:0] in,
   input  logic [ADDR_W-1:0]        PA_in,
   input  logic [ADDR_W-1:0]        PB_in,
   input  logic [ADDR_W-1:0]        PC_in,
   input  logic                     enable,
   input  logic [WIN_W-1:0]         current_window
);

   logic [DATA_W-1:0] regs_q [NPHYS];
   physIdx_t          paIdx;
   physIdx_t          pbIdx;
   physIdx_t          pcIdx;

   regfile_addr_map uMapA (.addr_i(PA_in), .win_i(current_window), .phys_o(paIdx));
   regfile_addr_map uMapB (.addr_i(PB_in), .win_i(current_window), .phys_o(pbIdx));
   regfile_addr_map uMapC (.addr_i(PC_in), .win_i(current_window), .phys_o(pcIdx));

   // Only r0 maps to physical 0. That slot is never written, so r0 stays hard-wired to zero.
   // Clear takes priority over a write on the same edge.
   always_ff @(posedge Clk) begin
      if (pcIdx != '0) begin
         if (Clr) begin
            regs_q[pcIdx] <= '0;
         end else if (enable) begin
            regs_q[pcIdx] <= in;
         end
      end
   end

   // Read muxes. The r0 check comes first, so forwarding can never make r0 non-zero.
   always_comb begin
      PA_out = (paIdx == '0) ? '0 : regs_q[paIdx];
      PB_out = (pbIdx == '0) ? '0 : regs_q[pbIdx];
`ifdef REGFILE_BYPASS_EN
      if ((enable || Clr) && (paIdx == pcIdx) && (paIdx != '0)) begin
         PA_out = Clr ? '0 : in;
      end
      if ((enable || Clr) && (pbIdx == pcIdx) && (pbIdx != '0)) begin
         PB_out = Clr ? '0 : in;
      end
`endif
   end

endmodule

// File: tb/tb_sparc_windowed_regfile.sv
// Testbench for sparc_windowed_regfile.
//
// The stimulus process drives one cycle at a time. In every cycle that has a
// read to check, it pushes the expected port A/B values into a queue and
// raises obsValid. The monitor samples on the falling edge and compares.
module tb_sparc_windowed_regfile;

   logic               clk = 1'b0;
   logic               clr;
   logic signed [31:0] paOut;
   logic signed [31:0] pbOut;
   logic signed [31:0] dataIn;
   logic [4:0]         paIn;
   logic [4:0]         pbIn;
   logic [4:0]         pcIn;
   logic               en;
   logic [1:0]         win;
   logic               obsValid = 1'b0;

   typedef struct {
      logic [31:0] expA;
      logic [31:0] expB;
      string       name;
   } expect_t;

   expect_t sbQ[$];
   int      total = 0;
   int      bad = 0;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   sparc_windowed_regfile dut (
      .Clk(clk), .Clr(clr), .PA_out(paOut), .PB_out(pbOut), .in(dataIn),
      .PA_in(paIn), .PB_in(pbIn), .PC_in(pcIn), .enable(en),
      .current_window(win)
   );

   // Free-running clock, with a hard timeout in case the bench wedges.
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, queue=%0d", sbQ.size());
      $fatal(1, "[TB] watchdog expired");
   end

   // Monitor: pop and compare whenever the bench marks the outputs as observable.
   always @(negedge clk) begin
      if (obsValid) begin
         if (sbQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_underflow: observation with no expected entry");
         end else begin
            expect_t e;
            e = sbQ.pop_front();
            total++;
            if (paOut !== e.expA) begin
               bad++;
               $display("[TB] FAIL %s portA: got %0h want %0h", e.name, paOut, e.expA);
            end
            total++;
            if (pbOut !== e.expB) begin
               bad++;
               $display("[TB] FAIL %s portB: got %0h want %0h", e.name, pbOut, e.expB);
            end
         end
      end
   end

   // One clock of stimulus. Inputs change just after a rising edge. When
   // check is set, the expected reads are queued for the monitor.
   task automatic applyStimulus(input logic w, input logic c, input logic [4:0] pc,
                                input logic [31:0] d, input logic [1:0] cw,
                                input logic [4:0] pa, input logic [4:0] pb,
                                input logic check, input logic [31:0] eA,
                                input logic [31:0] eB, input string nm);
      en     = w;
      clr    = c;
      pcIn   = pc;
      dataIn = d;
      win    = cw;
      paIn   = pa;
      pbIn   = pb;
      if (check) begin
         expect_t e;
         e.expA = eA;
         e.expB = eB;
         e.name = nm;
         sbQ.push_back(e);
      end
      obsValid = check;
      @(posedge clk);
      #1;
      obsValid = 1'b0;
   endtask

   task automatic writeReg(input logic [1:0] cw, input logic [4:0] pc, input logic [31:0] d);
      applyStimulus(1'b1, 1'b0, pc, d, cw, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, "");
   endtask

   task automatic checkOutput(input logic [1:0] cw, input logic [4:0] pa, input logic [4:0] pb,
                              input logic [31:0] eA, input logic [31:0] eB, input string nm);
      applyStimulus(1'b0, 1'b0, 5'd0, 32'hDEAD_BEEF, cw, pa, pb, 1'b1, eA, eB, nm);
   endtask

   initial begin
      en = 0; clr = 0; pcIn = 0; dataIn = 0; win = 0; paIn = 0; pbIn = 0;
      @(posedge clk);
      #1;

      // Fill window 0 with r1..r31 = 1..31, then read the values back in pairs.
      for (int k = 1; k < 32; k++) writeReg(2'd0, 5'(k), 32'(k));
      for (int k = 0; k < 16; k++)
         checkOutput(2'd0, 5'(k), 5'(31 - k), 32'(k), 32'(31 - k), $sformatf("fill_r%0d", k));

      // Overlap: w1 outs alias w0 ins.
      writeReg(2'd1, 5'd8, 32'h111);
      checkOutput(2'd0, 5'd24, 5'd8, 32'h111, 32'd8, "overlap_w1r8_w0r24");

      // Wrap: w0 outs alias w3 ins.
      writeReg(2'd0, 5'd8, 32'h222);
      checkOutput(2'd3, 5'd24, 5'd0, 32'h222, 32'd0, "wrap_w0r8_w3r24");

      // Globals are shared by all windows. Writes to r0 are discarded.
      writeReg(2'd2, 5'd3, 32'd77);
      checkOutput(2'd0, 5'd3, 5'd1, 32'd77, 32'd1, "global_w0");
      checkOutput(2'd1, 5'd3, 5'd2, 32'd77, 32'd2, "global_w1");
      checkOutput(2'd3, 5'd3, 5'd4, 32'd77, 32'd4, "global_w3");
      writeReg(2'd0, 5'd0, 32'd55);
      checkOutput(2'd0, 5'd0, 5'd0, 32'd0, 32'd0, "r0_ignores_write");

      // Clearing a global clears it in every window. Clearing a windowed register clears only that window's copy.
      writeReg(2'd1, 5'd31, 32'h333);
      applyStimulus(1'b0, 1'b1, 5'd3, 32'd0, 2'd0, 5'd0, 5'd0, 1'b0, 0, 0, "");
      checkOutput(2'd0, 5'd3, 5'd2, 32'd0, 32'd2, "clear_global_w0");
      checkOutput(2'd2, 5'd3, 5'd0, 32'd0, 32'd0, "clear_global_w2");
      applyStimulus(1'b0, 1'b1, 5'd31, 32'd0, 2'd0, 5'd0, 5'd0, 1'b0, 0, 0, "");
      checkOutput(2'd0, 5'd31, 5'd30, 32'd0, 32'd30, "clear_w0r31");
      checkOutput(2'd1, 5'd31, 5'd0, 32'h333, 32'd0, "w1r31_kept");

      // Clear beats write. With enable low, nothing is written.
      applyStimulus(1'b1, 1'b1, 5'd5, 32'd9, 2'd0, 5'd0, 5'd0, 1'b0, 0, 0, "");
      checkOutput(2'd0, 5'd5, 5'd6, 32'd0, 32'd6, "clr_priority");
      applyStimulus(1'b0, 1'b0, 5'd6, 32'd1234, 2'd0, 5'd0, 5'd0, 1'b0, 0, 0, "");
      checkOutput(2'd0, 5'd6, 5'd5, 32'd6, 32'd0, "enable_low_nochange");

      // Read during write. The result depends on whether forwarding is built in.
      applyStimulus(1'b1, 1'b0, 5'd6, 32'd42, 2'd0, 5'd6, 5'd7, 1'b1,
                    BYPASS ? 32'd42 : 32'd6, 32'd7, "bypass_write");
      checkOutput(2'd0, 5'd6, 5'd6, 32'd42, 32'd42, "after_write");
      applyStimulus(1'b0, 1'b1, 5'd7, 32'd0, 2'd0, 5'd1, 5'd7, 1'b1,
                    32'd1, BYPASS ? 32'd0 : 32'd7, "bypass_clear");
      checkOutput(2'd0, 5'd7, 5'd0, 32'd0, 32'd0, "after_clear");

      @(posedge clk);
      #1;
      if (sbQ.size() != 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, want 0", sbQ.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
